// File: rtl/jtlabrun_fmbus_if.sv
// CPU-side and FM-side signal bundle for the Labyrinth Runner YM2203 bus
// controller. The slave modport is the controller itself; the master modport
// is everything around it (CPU decoder, FM clock-enable source, both chips).
interface jtlabrun_fmbus_if;
    // CPU side
    logic       ym0_cs;
    logic       ym1_cs;
    logic       cpu_rnw;
    logic       cpu_a0;
    logic [7:0] cpu_dout;
    logic       waitn;
    logic [7:0] ym_dout;
    // FM side
    logic       cen_fm;
    logic [1:0] fm_cs_n;
    logic       fm_wr_n;
    logic       fm_addr;
    logic [7:0] fm_din;
    logic [7:0] fm0_dout;
    logic [7:0] fm1_dout;
    logic [1:0] fm_busy;

    modport slave (
        input  ym0_cs, ym1_cs, cpu_rnw, cpu_a0, cpu_dout,
        input  cen_fm, fm0_dout, fm1_dout,
        output waitn, ym_dout,
        output fm_cs_n, fm_wr_n, fm_addr, fm_din, fm_busy
    );

    modport master (
        output ym0_cs, ym1_cs, cpu_rnw, cpu_a0, cpu_dout,
        output cen_fm, fm0_dout, fm1_dout,
        input  waitn, ym_dout,
        input  fm_cs_n, fm_wr_n, fm_addr, fm_din, fm_busy
    );
endinterface

// File: rtl/jtlabrun_fmbus.sv
// Serialises main-CPU accesses onto the two YM2203 chips. The CPU is stalled
// via waitn while the access waits for the chip's write-recovery interval and
// then runs one full cen_fm period of chip select / write strobe. Read data is
// captured on the strobe release edge and held for the CPU din mux.
module jtlabrun_fmbus #(
    parameter int ADDR_BUSY = 2,
    parameter int DATA_BUSY = 17,
    parameter int CW        = 5
) (
    input  logic              clk,
    input  logic              rst,
    jtlabrun_fmbus_if.slave   bus
);
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BUSYW,
        ST_SETUP,
        ST_STROBE,
        ST_DONE
    } state_t;

    localparam logic [CW-1:0] ADDR_LOAD = CW'(ADDR_BUSY);
    localparam logic [CW-1:0] DATA_LOAD = CW'(DATA_BUSY);

    state_t        state_q, state_d;
    logic          sel_q, sel_d;        // 0 = chip 0, 1 = chip 1
    logic          a0_q, a0_d;
    logic          rnw_q, rnw_d;
    logic [7:0]    wdata_q, wdata_d;
    logic [1:0]    cs_n_q, cs_n_d;
    logic          wr_n_q, wr_n_d;
    logic          addr_q, addr_d;
    logic [7:0]    din_q, din_d;
    logic [7:0]    rdata_q, rdata_d;
    logic          load_en;
    logic [CW-1:0] load_val;
    logic [1:0]    busy;
    logic          cs_any;

    assign cs_any = bus.ym0_cs | bus.ym1_cs;

    // Next-state and output decisions; losing the select anywhere before DONE
    // abandons the access and releases the strobes on the following edge.
    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        a0_d     = a0_q;
        rnw_d    = rnw_q;
        wdata_d  = wdata_q;
        cs_n_d   = cs_n_q;
        wr_n_d   = wr_n_q;
        addr_d   = addr_q;
        din_d    = din_q;
        rdata_d  = rdata_q;
        load_en  = 1'b0;
        load_val = ADDR_LOAD;
        case (state_q)
            ST_IDLE: begin
                if (cs_any) begin
                    sel_d   = ~bus.ym0_cs;      // chip 0 wins a double select
                    a0_d    = bus.cpu_a0;
                    rnw_d   = bus.cpu_rnw;
                    wdata_d = bus.cpu_dout;
                    state_d = ST_BUSYW;
                end
            end
            ST_BUSYW: begin
                if (!cs_any) begin
                    cs_n_d  = 2'b11;
                    wr_n_d  = 1'b1;
                    state_d = ST_IDLE;
                end else if (!busy[sel_q]) begin
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (!cs_any) begin
                    cs_n_d  = 2'b11;
                    wr_n_d  = 1'b1;
                    state_d = ST_IDLE;
                end else if (bus.cen_fm) begin
                    cs_n_d  = sel_q ? 2'b01 : 2'b10;
                    wr_n_d  = rnw_q;
                    addr_d  = a0_q;
                    din_d   = wdata_q;
                    state_d = ST_STROBE;
                end
            end
            ST_STROBE: begin
                if (!cs_any) begin
                    cs_n_d  = 2'b11;
                    wr_n_d  = 1'b1;
                    state_d = ST_IDLE;
                end else if (bus.cen_fm) begin
                    cs_n_d  = 2'b11;
                    wr_n_d  = 1'b1;
                    if (rnw_q) begin
                        rdata_d = sel_q ? bus.fm1_dout : bus.fm0_dout;
                    end else begin
                        load_en  = 1'b1;
                        load_val = a0_q ? DATA_LOAD : ADDR_LOAD;
                    end
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (!cs_any) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, latched access and FM bus output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sel_q   <= 1'b0;
            a0_q    <= 1'b0;
            rnw_q   <= 1'b1;
            wdata_q <= 8'h00;
            cs_n_q  <= 2'b11;
            wr_n_q  <= 1'b1;
            addr_q  <= 1'b0;
            din_q   <= 8'h00;
            rdata_q <= 8'hff;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            a0_q    <= a0_d;
            rnw_q   <= rnw_d;
            wdata_q <= wdata_d;
            cs_n_q  <= cs_n_d;
            wr_n_q  <= wr_n_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            rdata_q <= rdata_d;
        end
    end

    // One write-recovery counter per chip; a fresh load beats the decrement.
    for (genvar gi = 0; gi < 2; gi++) begin : g_busy
        logic [CW-1:0] cnt_q, cnt_d;

        // Load on a completed write to this chip, else count cen_fm down to 0.
        always_comb begin
            cnt_d = cnt_q;
            if (load_en && (sel_q == 1'(gi))) begin
                cnt_d = load_val;
            end else if (bus.cen_fm && (cnt_q != '0)) begin
                cnt_d = cnt_q - CW'(1);
            end
        end

        // Counter register, cleared by reset.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end

        assign busy[gi] = (cnt_q != '0);
    end

    assign bus.fm_busy = busy;
    assign bus.fm_cs_n = cs_n_q;
    assign bus.fm_wr_n = wr_n_q;
    assign bus.fm_addr = addr_q;
    assign bus.fm_din  = din_q;
    assign bus.ym_dout = rdata_q;
    // The CPU runs freely during reset and whenever it is not addressing the FM
    // chips; an access holds it until the chip transfer has finished.
    assign bus.waitn   = rst | ~cs_any | (state_q == ST_DONE);
endmodule

// File: tb/tb_jtlabrun_fmbus.sv
// Scoreboard bench for jtlabrun_fmbus. Stimulus pushes the expected strobe,
// completion and busy-interval records; three monitors pop and compare them
// as the DUT presents strobes, completed accesses and busy intervals.
module tb_jtlabrun_fmbus;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    jtlabrun_fmbus_if bus();

    jtlabrun_fmbus #(.ADDR_BUSY(2), .DATA_BUSY(17), .CW(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [1:0] cs_n;
        logic       wr_n;
        logic       addr;
        logic [7:0] din;
        int         gap;    // required cen_fm ticks since previous release, -1 = any
    } strobe_t;

    typedef struct {
        logic [7:0] ym;
        logic [1:0] busy;
    } done_t;

    strobe_t exp_strobe_q[$];
    done_t   exp_done_q[$];
    int      exp_busy0_q[$];
    int      exp_busy1_q[$];

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    task automatic expect_strobe(input logic [1:0] cs_n, input logic wr_n, input logic addr,
                                 input logic [7:0] din, input int gap);
        strobe_t s;
        s.cs_n = cs_n; s.wr_n = wr_n; s.addr = addr; s.din = din; s.gap = gap;
        exp_strobe_q.push_back(s);
    endtask

    task automatic expect_done(input logic [7:0] ym, input logic [1:0] busy);
        done_t d;
        d.ym = ym; d.busy = busy;
        exp_done_q.push_back(d);
    endtask

    // Free-running FM clock enable: one clk high out of every 8.
    logic [2:0] cen_div = 3'd0;
    initial begin
        bus.cen_fm = 1'b0;
        forever begin
            @(negedge clk);
            cen_div = cen_div + 3'd1;
            bus.cen_fm = (cen_div == 3'd7);
        end
    end

    // Strobe monitor: measures each chip-select pulse and compares it on release.
    int      tick_cnt = 0;
    int      last_rel = 0;
    int      start_tick = 0;
    int      width = 0;
    logic    in_strobe = 1'b0;
    logic    stable = 1'b1;
    strobe_t cap;
    strobe_t se;
    always @(posedge clk) begin
        #1;
        if (bus.cen_fm) tick_cnt++;
        if (rst) begin
            in_strobe = 1'b0;
        end else if (bus.fm_cs_n != 2'b11) begin
            if (!in_strobe) begin
                in_strobe  = 1'b1;
                width      = 1;
                stable     = 1'b1;
                cap.cs_n   = bus.fm_cs_n;
                cap.wr_n   = bus.fm_wr_n;
                cap.addr   = bus.fm_addr;
                cap.din    = bus.fm_din;
                cap.gap    = 0;
                start_tick = tick_cnt;
            end else begin
                width++;
                if (bus.fm_cs_n !== cap.cs_n || bus.fm_wr_n !== cap.wr_n ||
                    bus.fm_addr !== cap.addr || bus.fm_din !== cap.din)
                    stable = 1'b0;
            end
        end else if (in_strobe) begin
            in_strobe = 1'b0;
            if (exp_strobe_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_strobe: got cs_n=%b required none", cap.cs_n);
            end else begin
                se = exp_strobe_q.pop_front();
                check("strobe_cs_n", 32'(cap.cs_n), 32'(se.cs_n));
                check("strobe_wr_n", 32'(cap.wr_n), 32'(se.wr_n));
                check("strobe_addr", 32'(cap.addr), 32'(se.addr));
                check("strobe_din", 32'(cap.din), 32'(se.din));
                check("strobe_width", 32'(width), 32'd8);
                check("strobe_stable", 32'(stable), 32'd1);
                if (se.gap >= 0)
                    check("strobe_gap", 32'(start_tick - last_rel), 32'(se.gap));
                $display("strobe cs_n=%b wr_n=%b a0=%b din=%02h width=%0d", cap.cs_n,
                         cap.wr_n, cap.addr, cap.din, width);
            end
            last_rel = tick_cnt;
        end
    end

    // Completion monitor: an access completes when waitn rises with a select held.
    logic  done_prev = 1'b0;
    logic  done_now;
    int    n_acc = 0;
    done_t de;
    always @(posedge clk) begin
        #1;
        done_now = !rst && (bus.ym0_cs | bus.ym1_cs) && bus.waitn;
        if (done_now && !done_prev) begin
            n_acc++;
            if (exp_done_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_done: got access %0d required none", n_acc);
            end else begin
                de = exp_done_q.pop_front();
                check("done_ym_dout", 32'(bus.ym_dout), 32'(de.ym));
                check("done_fm_busy", 32'(bus.fm_busy), 32'(de.busy));
                $display("access %0d done ym_dout=%02h fm_busy=%b", n_acc, bus.ym_dout,
                         bus.fm_busy);
            end
        end
        done_prev = done_now;
    end

    // Busy monitor: counts cen_fm decrements over each busy interval per chip.
    logic [1:0] busy_prev = 2'b00;
    int         bticks0 = 0;
    int         bticks1 = 0;
    always @(posedge clk) begin
        #1;
        if (rst) begin
            busy_prev = 2'b00;
            bticks0 = 0;
            bticks1 = 0;
            exp_busy0_q.delete();
            exp_busy1_q.delete();
        end else begin
            if (busy_prev[0] && bus.cen_fm) bticks0++;
            if (busy_prev[1] && bus.cen_fm) bticks1++;
            if (busy_prev[0] && !bus.fm_busy[0]) begin
                if (exp_busy0_q.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL unexpected_busy0: got %0d ticks required none", bticks0);
                end else begin
                    check("busy0_ticks", 32'(bticks0), 32'(exp_busy0_q.pop_front()));
                end
                bticks0 = 0;
            end
            if (busy_prev[1] && !bus.fm_busy[1]) begin
                if (exp_busy1_q.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL unexpected_busy1: got %0d ticks required none", bticks1);
                end else begin
                    check("busy1_ticks", 32'(bticks1), 32'(exp_busy1_q.pop_front()));
                end
                bticks1 = 0;
            end
            busy_prev = bus.fm_busy;
        end
    end

    // One CPU access: select, wait for waitn, release, one idle clk.
    task automatic access(input logic chip, input logic rnw, input logic a0,
                          input logic [7:0] wd);
        int k;
        bus.ym0_cs   = (chip == 1'b0);
        bus.ym1_cs   = (chip == 1'b1);
        bus.cpu_rnw  = rnw;
        bus.cpu_a0   = a0;
        bus.cpu_dout = wd;
        #1 check("waitn_low_on_select", 32'(bus.waitn), 32'd0);
        for (k = 0; k < 400; k++) begin
            @(negedge clk);
            if (bus.waitn) break;
        end
        if (k == 400) begin
            n_cmp++; n_err++;
            $display("FAIL access_timeout: got waitn=0 required 1 within 400 clk");
        end
        bus.ym0_cs = 1'b0;
        bus.ym1_cs = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        rst = 1'b1;
        bus.ym0_cs = 1'b0; bus.ym1_cs = 1'b0;
        bus.cpu_rnw = 1'b1; bus.cpu_a0 = 1'b0; bus.cpu_dout = 8'h00;
        bus.fm0_dout = 8'h00; bus.fm1_dout = 8'h00;
        repeat (2) @(negedge clk);

        // Reset state
        check("rst_fm_cs_n", 32'(bus.fm_cs_n), 32'h3);
        check("rst_fm_wr_n", 32'(bus.fm_wr_n), 32'h1);
        check("rst_fm_addr", 32'(bus.fm_addr), 32'h0);
        check("rst_fm_din", 32'(bus.fm_din), 32'h00);
        check("rst_ym_dout", 32'(bus.ym_dout), 32'hff);
        check("rst_fm_busy", 32'(bus.fm_busy), 32'h0);
        bus.ym0_cs = 1'b1;
        #1 check("rst_waitn_with_cs", 32'(bus.waitn), 32'h1);
        bus.ym0_cs = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Single address write to chip 0
        expect_strobe(2'b10, 1'b0, 1'b0, 8'h27, -1);
        expect_done(8'hff, 2'b01);
        exp_busy0_q.push_back(2);
        access(1'b0, 1'b0, 1'b0, 8'h27);
        repeat (30) @(negedge clk);

        // Back-to-back address then data write to chip 1: data waits out 2 ticks
        expect_strobe(2'b01, 1'b0, 1'b0, 8'h28, -1);
        expect_done(8'hff, 2'b10);
        exp_busy1_q.push_back(2);
        access(1'b1, 1'b0, 1'b0, 8'h28);
        expect_strobe(2'b01, 1'b0, 1'b1, 8'hf0, 3);
        expect_done(8'hff, 2'b10);
        exp_busy1_q.push_back(17);
        access(1'b1, 1'b0, 1'b1, 8'hf0);
        repeat (160) @(negedge clk);

        // Read from chip 1
        bus.fm1_dout = 8'h5a;
        bus.fm0_dout = 8'h00;
        expect_strobe(2'b01, 1'b1, 1'b1, 8'h33, -1);
        expect_done(8'h5a, 2'b00);
        access(1'b1, 1'b1, 1'b1, 8'h33);
        repeat (4) @(negedge clk);

        // Data write to chip 0, then chip 1 read with no stall
        expect_strobe(2'b10, 1'b0, 1'b1, 8'h9c, -1);
        expect_done(8'h5a, 2'b01);
        exp_busy0_q.push_back(17);
        access(1'b0, 1'b0, 1'b1, 8'h9c);
        bus.fm1_dout = 8'ha5;
        expect_strobe(2'b01, 1'b1, 1'b0, 8'h11, 1);
        expect_done(8'ha5, 2'b01);
        access(1'b1, 1'b1, 1'b0, 8'h11);

        // Async reset while a chip 1 write is strobing and chip 0 is busy
        bus.ym1_cs = 1'b1; bus.cpu_rnw = 1'b0; bus.cpu_a0 = 1'b0; bus.cpu_dout = 8'h44;
        for (k = 0; k < 100; k++) begin
            @(posedge clk);
            #1;
            if (bus.fm_cs_n != 2'b11) break;
        end
        if (k == 100) begin
            n_cmp++; n_err++;
            $display("FAIL strobe_timeout: got no strobe required strobe within 100 clk");
        end
        check("busy_before_reset", 32'(bus.fm_busy), 32'h1);
        #2 rst = 1'b1;
        #1;
        check("arst_fm_cs_n", 32'(bus.fm_cs_n), 32'h3);
        check("arst_fm_wr_n", 32'(bus.fm_wr_n), 32'h1);
        check("arst_fm_busy", 32'(bus.fm_busy), 32'h0);
        check("arst_waitn", 32'(bus.waitn), 32'h1);
        @(negedge clk);
        bus.ym1_cs = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_reset_ym_dout", 32'(bus.ym_dout), 32'hff);

        // Abort: select dropped while in SETUP
        bus.ym0_cs = 1'b1; bus.cpu_rnw = 1'b0; bus.cpu_a0 = 1'b1; bus.cpu_dout = 8'h66;
        #1 check("abort_waitn_low", 32'(bus.waitn), 32'h0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        bus.ym0_cs = 1'b0;
        @(posedge clk);
        #1;
        check("abort_fm_cs_n", 32'(bus.fm_cs_n), 32'h3);
        check("abort_waitn", 32'(bus.waitn), 32'h1);
        check("abort_fm_busy", 32'(bus.fm_busy), 32'h0);
        check("abort_ym_dout", 32'(bus.ym_dout), 32'hff);
        repeat (20) @(negedge clk);
        check("abort_no_load", 32'(bus.fm_busy), 32'h0);

        // Normal access after the abort
        expect_strobe(2'b10, 1'b0, 1'b0, 8'h5b, -1);
        expect_done(8'hff, 2'b01);
        exp_busy0_q.push_back(2);
        access(1'b0, 1'b0, 1'b0, 8'h5b);
        repeat (30) @(negedge clk);

        check("strobe_q_drained", 32'(exp_strobe_q.size()), 32'd0);
        check("done_q_drained", 32'(exp_done_q.size()), 32'd0);
        check("busy0_q_drained", 32'(exp_busy0_q.size()), 32'd0);
        check("busy1_q_drained", 32'(exp_busy1_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
